// File: rtl/ps_bram_pixel_packer_if.sv
// Bundle of the packer's control, BRAM read port and output stream signals.
// The packer uses the master view. A frame source plus BRAM model plus sink
// uses the slave view.
interface ps_bram_pixel_packer_if #(
  parameter int CH     = 3,
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 13,
  parameter int BUS_W  = 64
);
  // Frame control
  logic                  start;
  logic [ADDR_W-1:0]     frame_len;
  logic [ADDR_W-1:0]     total_len;
  logic                  busy;
  logic                  done;

  // Shared BRAM read port, one data lane per channel
  logic                  bram_en;
  logic [ADDR_W-1:0]     bram_addr;
  logic [CH*PIX_W-1:0]   bram_dout;

  // Packed output stream
  logic [BUS_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, frame_len, total_len, bram_dout, out_ready,
    output busy, done, bram_en, bram_addr, out_data, out_valid
  );

  modport slave (
    output start, frame_len, total_len, bram_dout, out_ready,
    input  busy, done, bram_en, bram_addr, out_data, out_valid
  );
endinterface

// File: rtl/ps_bram_pixel_packer.sv
// Reads CH parallel channel BRAMs at a shared address. Packs one sample per
// channel into a bus-wide beat, with zero beats for addresses past the real
// frame. The beats go into a small show-ahead FIFO. Reads are credit-limited
// so the FIFO can never overflow, whatever the sink does with out_ready.
module ps_bram_pixel_packer #(
  parameter int CH     = 3,
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 13,
  parameter int BUS_W  = 64,
  parameter int RD_LAT = 1
) (
  input  logic                   clk_fast,
  input  logic                   reset,
  ps_bram_pixel_packer_if.master bus
);

  // The FIFO holds every read that can be in flight plus two beats of slack.
  // That slack lets the sink take one beat per cycle with no bubble.
  localparam int DEPTH = RD_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  // Parameter sanity, caught at elaboration
  if (CH < 1 || CH > 4) begin : g_bad_ch
    $error("ps_bram_pixel_packer: CH must be in 1..4");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("ps_bram_pixel_packer: RD_LAT must be in 1..4");
  end
  if (CH * PIX_W > BUS_W) begin : g_bad_bus
    $error("ps_bram_pixel_packer: CH*PIX_W must not exceed BUS_W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W:0]    addr_cnt;   // one spare bit so the count never wraps
  logic               busy_q;
  logic               done_q;

  logic [RD_LAT-1:0]  vld_pipe;   // marks cycles whose bram_dout is a real read
  logic [RD_LAT-1:0]  pad_pipe;   // pad tag travelling with each read

  logic [BUS_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [OCC_W-1:0]   occ;
  logic               issue;
  logic               last_issue;
  logic               pad_tag;
  logic               push;
  logic               pop;
  logic               last_pop;
  logic [BUS_W-1:0]   packed_beat;
  logic [BUS_W-1:0]   wr_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Credit count: reads still in the BRAM pipeline plus beats parked in the FIFO
  always_comb begin
    // NOTE: always_comb uses blocking '=' so the accumulation reads its own
    // running value. Clocked state elsewhere uses '<=' so every flop samples
    // pre-edge values.
    occ = OCC_W'(count);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OCC_W'(vld_pipe[i]);
    end
  end

  assign issue      = (state == S_RUN) && (occ < OCC_FULL);
  assign last_issue = issue && ((addr_cnt + ADDR_ONE) == {1'b0, bus.total_len});
  assign pad_tag    = (addr_cnt >= {1'b0, bus.frame_len});
  assign push       = vld_pipe[RD_LAT-1];
  assign pop        = (count != '0) && bus.out_ready;
  // The beat leaving now is the last one when nothing else is queued or in flight
  assign last_pop   = pop && (occ == OCC_ONE);

  // Reorder channels so channel 0 lands in the most significant used lane
  always_comb begin
    // NOTE: assign a default to the whole word first. Then no bit is left
    // unassigned on any path, and no latch is inferred.
    packed_beat = '0;
    for (int k = 0; k < CH; k++) begin
      packed_beat[(CH-1-k)*PIX_W +: PIX_W] = bus.bram_dout[k*PIX_W +: PIX_W];
    end
  end

  assign wr_data = pad_pipe[RD_LAT-1] ? '0 : packed_beat;

  // Frame sequencer: address generation, busy and the done pulse
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q   <= 1'b1;
            addr_cnt <= '0;
            if (bus.total_len == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            addr_cnt <= addr_cnt + ADDR_ONE;
            if (last_issue) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Read-tag pipeline and FIFO bookkeeping
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      pad_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      vld_pipe[0] <= issue;
      pad_pipe[0] <= pad_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pad_pipe[i] <= pad_pipe[i-1];
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk_fast) begin
    // NOTE: the storage array has no reset. An entry is only visible after it
    // has been written, and out_data is forced to zero whenever the FIFO is
    // empty, so stale contents can never escape.
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr_cnt[ADDR_W-1:0];
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ps_bram_pixel_packer.sv
// Directed bench for ps_bram_pixel_packer. One instance uses RD_LAT=1 and one
// uses RD_LAT=3, and each has a behavioural BRAM. Channel k at address a holds
// 0x1000*(k+1)+a.
module tb_ps_bram_pixel_packer;

  localparam int CH     = 3;
  localparam int PIX_W  = 16;
  localparam int ADDR_W = 13;
  localparam int BUS_W  = 64;

  logic clk_fast = 1'b0;
  logic reset;

  always #5 clk_fast = ~clk_fast;

  ps_bram_pixel_packer_if #(.CH(CH), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus1 ();
  ps_bram_pixel_packer_if #(.CH(CH), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus3 ();

  ps_bram_pixel_packer #(
    .CH(CH), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W), .RD_LAT(1)
  ) dut1 (
    .clk_fast (clk_fast),
    .reset    (reset),
    .bus      (bus1)
  );

  ps_bram_pixel_packer #(
    .CH(CH), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W), .RD_LAT(3)
  ) dut3 (
    .clk_fast (clk_fast),
    .reset    (reset),
    .bus      (bus3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] bram_word(input logic [ADDR_W-1:0] a);
    logic [15:0] a16;
    a16 = {3'b000, a};
    return {16'h3000 + a16, 16'h2000 + a16, 16'h1000 + a16};
  endfunction

  function automatic logic [63:0] exp_beat(input int a, input int flen);
    logic [15:0] a16;
    a16 = 16'(a);
    if (a < flen) return {16'h0000, 16'h1000 + a16, 16'h2000 + a16, 16'h3000 + a16};
    return 64'h0;
  endfunction

  function automatic logic ready_pat(input int i);
    return ((i % 4) == 0) || ((i % 4) == 3);
  endfunction

  // Behavioural BRAMs: latency 1 for dut1, latency 3 for dut3
  logic [47:0] b3_s0, b3_s1;
  always @(posedge clk_fast) begin
    if (bus1.bram_en) bus1.bram_dout <= bram_word(bus1.bram_addr);
    if (bus3.bram_en) b3_s0 <= bram_word(bus3.bram_addr);
    b3_s1 <= b3_s0;
    bus3.bram_dout <= b3_s1;
  end

  // Output monitor, sampled mid-cycle
  logic [63:0] q1[$];
  logic [63:0] q3[$];
  int done1 = 0, done3 = 0, en1 = 0, en3 = 0, thr1 = 0, stab1 = 0;
  logic hold1 = 1'b0;
  logic [63:0] hold_data1 = '0;

  always @(negedge clk_fast) begin
    if (!reset) begin
      hold1 <= 1'b0;
    end else begin
      if (hold1 && (!bus1.out_valid || bus1.out_data != hold_data1)) stab1 <= stab1 + 1;
      hold1      <= bus1.out_valid && !bus1.out_ready;
      hold_data1 <= bus1.out_data;
      if (bus1.out_valid && bus1.out_ready) q1.push_back(bus1.out_data);
      if (bus3.out_valid && bus3.out_ready) q3.push_back(bus3.out_data);
      if (bus1.done) done1 <= done1 + 1;
      if (bus3.done) done3 <= done3 + 1;
      if (bus1.bram_en) en1 <= en1 + 1;
      if (bus3.bram_en) en3 <= en3 + 1;
      if (bus1.busy && !bus1.bram_en && bus1.bram_addr != '0 &&
          bus1.bram_addr < bus1.total_len) thr1 <= thr1 + 1;
    end
  end

  // Drive a one-cycle start; returns 1 time unit after the sampling edge E0
  task automatic start_frame(input bit use3, input int flen, input int tlen);
    @(posedge clk_fast); #1;
    if (use3) begin
      bus3.frame_len = ADDR_W'(flen);
      bus3.total_len = ADDR_W'(tlen);
      bus3.start     = 1'b1;
    end else begin
      bus1.frame_len = ADDR_W'(flen);
      bus1.total_len = ADDR_W'(tlen);
      bus1.start     = 1'b1;
    end
    @(posedge clk_fast); #1;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic wait_done(input bit use3, input int base, input int budget, input string tag);
    int n;
    n = 0;
    while (((use3 ? done3 : done1) == base) && n < budget) begin
      @(negedge clk_fast);
      n++;
    end
    repeat (3) @(negedge clk_fast);
    check({tag, " done pulses"}, 64'((use3 ? done3 : done1) - base), 64'd1);
  endtask

  task automatic check_beats(input bit use3, input int n, input int flen, input string tag);
    logic [63:0] q[$];
    if (use3) q = q3;
    else q = q1;
    check({tag, " beat count"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      check($sformatf("%s beat%0d", tag, i), q[i], exp_beat(i, flen));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, en_base, thr_base, stab_base, nvalid, n, sz, phase;

    reset          = 1'b1;
    bus1.start     = 1'b0; bus3.start     = 1'b0;
    bus1.frame_len = '0;   bus3.frame_len = '0;
    bus1.total_len = '0;   bus3.total_len = '0;
    bus1.out_ready = 1'b1; bus3.out_ready = 1'b1;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst bram_en",   64'(bus1.bram_en),   64'd0);
    check("rst bram_addr", 64'(bus1.bram_addr), 64'd0);
    check("rst out_valid", 64'(bus1.out_valid), 64'd0);
    check("rst out_data",  bus1.out_data,       64'd0);
    check("rst busy",      64'(bus1.busy),      64'd0);
    check("rst done",      64'(bus1.done),      64'd0);
    check("rst3 valid",    64'(bus3.out_valid), 64'd0);
    check("rst3 busy",     64'(bus3.busy),      64'd0);
    repeat (2) @(negedge clk_fast);
    reset = 1'b1;
    repeat (2) @(negedge clk_fast);

    // A: 4 real + 2 pad beats, sink always ready
    q1.delete(); base = done1; en_base = en1; thr_base = thr1;
    start_frame(0, 4, 6);
    check("A bram_en@E0",   64'(bus1.bram_en),   64'd1);
    check("A bram_addr@E0", 64'(bus1.bram_addr), 64'd0);
    check("A busy@E0",      64'(bus1.busy),      64'd1);
    check("A valid@E0",     64'(bus1.out_valid), 64'd0);
    @(posedge clk_fast); #1;
    check("A valid@E1",     64'(bus1.out_valid), 64'd0);
    @(posedge clk_fast); #1;
    check("A valid@E2",     64'(bus1.out_valid), 64'd1);
    check("A data@E2",      bus1.out_data,       64'h0000_1000_2000_3000);
    wait_done(0, base, 100, "A");
    check_beats(0, 6, 4, "A");
    check("A bram_en cycles", 64'(en1 - en_base), 64'd6);
    check("A throttle",       64'(thr1 - thr_base), 64'd0);
    check("A busy after",     64'(bus1.busy), 64'd0);

    // B: same frame, out_ready cycling 1,0,0,1
    q1.delete(); base = done1; en_base = en1; thr_base = thr1; stab_base = stab1;
    start_frame(0, 4, 6);
    phase = 0;
    while (done1 == base && phase < 200) begin
      bus1.out_ready = ready_pat(phase);
      @(posedge clk_fast); #1;
      phase++;
    end
    bus1.out_ready = 1'b1;
    wait_done(0, base, 10, "B");
    check_beats(0, 6, 4, "B");
    check("B bram_en cycles", 64'(en1 - en_base), 64'd6);
    check("B throttled",      64'((thr1 - thr_base) > 0), 64'd1);
    check("B stable on stall", 64'(stab1 - stab_base), 64'd0);

    // C: RD_LAT=3, 16 real beats back to back
    q3.delete(); base = done3;
    start_frame(1, 16, 16);
    check("C valid@E0", 64'(bus3.out_valid), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_fast); #1;
      check($sformatf("C valid@E%0d", k), 64'(bus3.out_valid), 64'd0);
    end
    @(posedge clk_fast); #1;
    check("C valid@E4", 64'(bus3.out_valid), 64'd1);
    nvalid = 1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk_fast); #1;
      if (bus3.out_valid) nvalid++;
    end
    check("C consecutive valid", 64'(nvalid), 64'd16);
    @(posedge clk_fast); #1;
    check("C valid after last", 64'(bus3.out_valid), 64'd0);
    wait_done(1, base, 50, "C");
    check_beats(1, 16, 16, "C");

    // D: reset in the middle of a 16-beat frame, then a fresh frame
    q1.delete();
    start_frame(0, 16, 16);
    n = 0;
    while (q1.size() < 3 && n < 50) begin
      @(negedge clk_fast);
      n++;
    end
    check("D 3 beats before reset", 64'(q1.size() >= 3), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("D rst bram_en",   64'(bus1.bram_en),   64'd0);
    check("D rst bram_addr", 64'(bus1.bram_addr), 64'd0);
    check("D rst out_valid", 64'(bus1.out_valid), 64'd0);
    check("D rst out_data",  bus1.out_data,       64'd0);
    check("D rst busy",      64'(bus1.busy),      64'd0);
    check("D rst done",      64'(bus1.done),      64'd0);
    @(negedge clk_fast);
    reset = 1'b1;
    sz = q1.size();
    repeat (8) @(negedge clk_fast);
    check("D no residual beat", 64'(q1.size() - sz), 64'd0);
    check("D idle after reset", 64'(bus1.busy), 64'd0);
    q1.delete(); base = done1;
    start_frame(0, 4, 6);
    check("D restart addr", 64'(bus1.bram_addr), 64'd0);
    check("D restart en",   64'(bus1.bram_en),   64'd1);
    wait_done(0, base, 100, "D");
    check_beats(0, 6, 4, "D");

    // E: start while busy is ignored; zero-length frame
    q1.delete(); base = done1;
    start_frame(0, 4, 6);
    repeat (2) @(posedge clk_fast); #1;
    bus1.start = 1'b1;
    @(posedge clk_fast); #1;
    bus1.start = 1'b0;
    wait_done(0, base, 100, "E");
    repeat (5) @(negedge clk_fast);
    check("E no second frame", 64'(done1 - base), 64'd1);
    check("E idle",            64'(bus1.busy),   64'd0);
    check_beats(0, 6, 4, "E");

    q1.delete(); base = done1; en_base = en1;
    start_frame(0, 0, 0);
    check("E0 busy@E0", 64'(bus1.busy),    64'd1);
    check("E0 done@E0", 64'(bus1.done),    64'd1);
    check("E0 en@E0",   64'(bus1.bram_en), 64'd0);
    @(posedge clk_fast); #1;
    check("E0 busy@E1", 64'(bus1.busy),    64'd0);
    check("E0 done@E1", 64'(bus1.done),    64'd0);
    repeat (3) @(negedge clk_fast);
    check("E0 no reads", 64'(en1 - en_base), 64'd0);
    check("E0 no beats", 64'(q1.size()),     64'd0);
    check("E0 one done", 64'(done1 - base),  64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
